// File: rtl/hh_pkg.sv
// Shared fixed-point constants, FSM state type and saturating helper for the neuron tile.
// Latency: none (declarations only).
// Backpressure: not applicable.
package hh_pkg;

    localparam int WIDTH        = 16;
    localparam int DECIMAL_BITS = 7;
    localparam int ONE          = 1 << DECIMAL_BITS;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } hh_state_t;

    // Unsigned add that clamps at 2^w-1 instead of wrapping (w <= 32).
    function automatic logic [31:0] sat_add_u(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/spike_trace.sv
// Leaky spike trace: decays by trace>>TAU_SHIFT each cycle, adds ONE per gated event, saturates.
// Latency: 1 cycle from ev_gated to trace.
// Backpressure: none; updates every cycle.
module spike_trace #(
    parameter int WIDTH        = hh_pkg::WIDTH,
    parameter int DECIMAL_BITS = hh_pkg::DECIMAL_BITS,
    parameter int TAU_SHIFT    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ev_gated,
    output logic [WIDTH-1:0] trace
);
    import hh_pkg::*;

    localparam logic [31:0] INC = 32'd1 << DECIMAL_BITS;

    logic [WIDTH-1:0] decayed;
    logic [WIDTH-1:0] trace_next;

    // Decay never underflows (subtracting a fraction of itself); only the add can overflow.
    always_comb begin
        decayed    = trace - (trace >> TAU_SHIFT);
        trace_next = WIDTH'(sat_add_u(32'(decayed), ev_gated ? INC : 32'd0, WIDTH));
    end

    // Trace register.
    always_ff @(posedge clk) begin
        if (reset) trace <= '0;
        else       trace <= trace_next;
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: per-window rising-edge count (valid/ready), leaky trace, optional ISI (SPIKE_DECODE_ISI_EN).
// Latency: rate_valid rises 1 cycle after the window-close cycle; trace/isi update 1 cycle after the edge.
// Backpressure: a window result arriving while an unaccepted result is held is dropped and sets sticky overrun.
module spike_rate_decoder #(
    parameter int WIDTH         = hh_pkg::WIDTH,
    parameter int DECIMAL_BITS  = hh_pkg::DECIMAL_BITS,
    parameter int WINDOW_CYCLES = 1024,
    parameter int COUNT_W       = 8,
    parameter int TAU_SHIFT     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               spike,
    output logic [COUNT_W-1:0] rate_out,
    output logic               rate_valid,
    input  logic               rate_ready,
    output logic               overrun,
    output logic [WIDTH-1:0]   trace_out
`ifdef SPIKE_DECODE_ISI_EN
    ,
    output logic [WIDTH-1:0]   isi_out,
    output logic               isi_valid
`endif
);
    import hh_pkg::*;

    localparam int                WCNT_W = $clog2(WINDOW_CYCLES);
    localparam logic [WCNT_W-1:0] WLAST  = WCNT_W'(WINDOW_CYCLES - 1);

    hh_state_t          state_q;
    hh_state_t          state_d;
    logic               spike_d;
    logic               ev;
    logic               count_en;
    logic               win_close;
    logic [WCNT_W-1:0]  wcnt;
    logic [COUNT_W-1:0] scnt;
    logic [COUNT_W-1:0] scnt_inc;

    assign ev        = spike & ~spike_d;
    // A window only closes (and publishes) while still enabled; dropping en discards it.
    assign count_en  = (state_q == COUNT) && en;
    assign win_close = count_en && (wcnt == WLAST);
    assign scnt_inc  = COUNT_W'(sat_add_u(32'(scnt), {31'd0, ev}, COUNT_W));

    // Spike delay for edge detection; runs in every state.
    always_ff @(posedge clk) begin
        if (reset) spike_d <= 1'b0;
        else       spike_d <= spike;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: en alone moves between IDLE and COUNT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en)  state_d = COUNT;
            COUNT:   if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Window and spike counters; an edge on the closing cycle is folded into the result.
    always_ff @(posedge clk) begin
        if (reset || !count_en || win_close) begin
            wcnt <= '0;
            scnt <= '0;
        end else begin
            wcnt <= wcnt + 1'b1;
            scnt <= scnt_inc;
        end
    end

    // Result publication and consumer handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            rate_out   <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (win_close) begin
            if (!rate_valid || rate_ready) begin
                rate_out   <= scnt_inc;
                rate_valid <= 1'b1;
            end else begin
                overrun    <= 1'b1;
            end
        end else if (rate_valid && rate_ready) begin
            rate_valid <= 1'b0;
        end
    end

    spike_trace #(
        .WIDTH        (WIDTH),
        .DECIMAL_BITS (DECIMAL_BITS),
        .TAU_SHIFT    (TAU_SHIFT)
    ) u_trace (
        .clk      (clk),
        .reset    (reset),
        .ev_gated (ev && (state_q == COUNT)),
        .trace    (trace_out)
    );

`ifdef SPIKE_DECODE_ISI_EN
    logic [WIDTH-1:0] isi_cnt;
    logic             isi_armed;

    // Inter-spike interval: first edge in COUNT arms, each later edge reports and restarts at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            isi_cnt   <= '0;
            isi_armed <= 1'b0;
            isi_out   <= '0;
            isi_valid <= 1'b0;
        end else begin
            isi_valid <= 1'b0;
            if (state_q == IDLE) begin
                isi_cnt   <= '0;
                isi_armed <= 1'b0;
            end else if (ev) begin
                if (isi_armed) begin
                    isi_out   <= isi_cnt;
                    isi_valid <= 1'b1;
                end
                isi_cnt   <= WIDTH'(1);
                isi_armed <= 1'b1;
            end else if (isi_armed) begin
                isi_cnt   <= WIDTH'(sat_add_u(32'(isi_cnt), 32'd1, WIDTH));
            end
        end
    end
`endif

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
Decodes a neuron spike train back into numeric form, the inverse of the current-to-spike encoding done by the hodgkin_huxley neurons. Measures spike rate over a fixed window and keeps a leaky spike trace. Results go out through a valid/ready interface to readout logic, e.g. the tile IO mux or a host register block. One instance per monitored spike line (spike1, spike2).

Parameters:
WIDTH, 16, fixed-point word width of trace_out
DECIMAL_BITS, 7, fractional bits; ONE = 1<<DECIMAL_BITS
WINDOW_CYCLES, 1024, rate window length in clk cycles (>=2)
COUNT_W, 8, width of the per-window spike counter
TAU_SHIFT, 4, trace decay shift: trace -= trace>>>TAU_SHIFT each cycle

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
en  input  1  decode enable; low holds the block idle
spike  input  1  level spike from neuron; may stay high for several cycles
rate_out  output  COUNT_W  spike count of the last completed window
rate_valid  output  1  rate_out holds an unconsumed result
rate_ready  input  1  consumer accepts rate_out when rate_valid && rate_ready
overrun  output  1  sticky: a window result was dropped
trace_out  output  WIDTH  leaky spike trace, unsigned Q(WIDTH-DECIMAL_BITS).DECIMAL_BITS

Behaviour:
- Interface (decided): one clock, clk; reset is synchronous and active-high, port reset.
- Reset values: rate_out=0, rate_valid=0, overrun=0, trace_out=0, window counter=0, spike counter=0, spike delay reg=0, state=IDLE.
- Edge detect: ev = spike & ~spike_d, where spike_d is spike registered each cycle, including in IDLE. Only rising edges count; a level held high counts once.
- FSM IDLE: counters held at 0; trace still decays but does not accumulate. en=1 -> COUNT on the next cycle.
- FSM COUNT: window counter wcnt increments 0..WINDOW_CYCLES-1. Each ev increments scnt, saturating at 2^COUNT_W-1.
- Window close: at wcnt==WINDOW_CYCLES-1, the result is scnt plus ev of that cycle, saturated. wcnt and scnt restart at 0 next cycle. An edge on the closing cycle belongs to the closing window.
- Publish: if rate_valid==0, or rate_valid && rate_ready in the same cycle, rate_out <= result and rate_valid <= 1 on the next edge. Otherwise the result is dropped, rate_out is kept, and overrun <= 1. overrun clears only on reset.
- Handshake: when rate_valid && rate_ready with no window close, rate_valid <= 0 next cycle. rate_out is stable while rate_valid=1 and not accepted.
- en deasserted mid-window: return to IDLE next cycle and discard the partial window (no publish). A pending rate_valid/rate_out stays until accepted.
- Trace, every cycle: trace <= sat(trace - (trace>>>TAU_SHIFT) + (ev && state==COUNT ? ONE : 0)), saturating at 2^WIDTH-1. No wrap-around.
- Latency: edge-detect register, then counter update. rate_valid rises exactly 1 cycle after the window-close cycle.
- reset mid-window or mid-handshake: everything returns to reset values next cycle.

Optional Feature:
Macro SPIKE_DECODE_ISI_EN.
- Defined: adds output isi_out [WIDTH-1:0] and isi_valid [0:0].
  - A cycle counter runs from the previous ev and saturates at 2^WIDTH-1.
  - On each ev after the first since entering COUNT: isi_out <= counter value, isi_valid pulses 1 cycle, counter restarts at 1.
  - First ev after entering COUNT only starts the counter.
  - IDLE clears the counter and the armed flag. Reset values are 0.
- Not defined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package hh_pkg: WIDTH, DECIMAL_BITS, ONE, unsigned saturating add function, FSM state typedef (IDLE, COUNT). Already usable by the neuron and synapse.
- One sub-module: spike_trace (params WIDTH, DECIMAL_BITS, TAU_SHIFT; inputs clk, reset, ev_gated; output trace). The STDP synapse can reuse it for its pre/post traces.

Test Plan:
- Reset while running: en=1, 3 edges, assert reset 1 cycle -> next cycle all outputs 0, state IDLE, no rate_valid.
- WINDOW_CYCLES=16, en=1, spike pulses (1 cycle high) every 4 cycles, rate_ready=1 -> rate_out=4, rate_valid one cycle per window; a spike held high 10 cycles counts 1.
- Edge on closing cycle (wcnt=15) -> counted in that window (rate_out=1 for a lone edge); next window starts at 0.
- rate_ready=0 over 2 windows with counts 3 then 5 -> rate_out stays 3, overrun=1; raise rate_ready -> accept, rate_valid drops, overrun stays 1.
- COUNT_W=2, 6 edges in one window -> rate_out=3 (saturated); single isolated edge, TAU_SHIFT=4 -> trace 128, then 120, 113 on the following cycles.
- SPIKE_DECODE_ISI_EN defined: edges at cycles 10, 17, 30 after entering COUNT -> isi_valid pulses with isi_out=7 then 13; en drop/raise -> next first edge produces no isi_valid.
